register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised, multi-read-port successor to the single-cycle register file, for the pipelined core.
- Provides NRD combinational read ports and one synchronous write port.
- Optional write-to-read bypass.
- Per-register scoreboard (busy bits) for hazard detection.
- Post-reset clearing sweep with a ready indication; the core stalls issue until ready is high.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero.
- NRD, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- SWEEP, 1, 1 = registers cleared one per cycle after reset; 0 = all cleared in the reset cycle.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  NRD*AW  packed read addresses, port p at [p*AW +: AW]; AW = $clog2(NREGS).
- rd_data  output  NRD*XLEN  packed read data, port p at [p*XLEN +: XLEN].
- rd_busy  output  NRD  port p source register has a pending producer.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write address.
- wr_data  input  XLEN  write data.
- issue_en  input  1  instruction issued that will write issue_rd.
- issue_rd  input  AW  destination of issued instruction.
- ready  output  1  register file initialised; reads, writes and issue accepted.

Behaviour:
- State machine, two states: RF_CLEAR, RF_READY.
  - reset=1 in any state, including mid-sweep: next state RF_CLEAR, sweep counter := 0, all busy bits := 0.
  - RF_CLEAR with SWEEP=1: each cycle, register[cnt] := 0 and cnt++. After the cycle with cnt == NREGS-1, state := RF_READY. Total NREGS cycles from reset deassertion to ready=1.
  - SWEEP=0: all registers := 0 in the reset cycle; RF_READY on the first cycle after reset deasserts.
- Reset values:
  - ready = 0.
  - rd_data = 0 on all ports.
  - rd_busy = 0.
  - ready = 1 only in RF_READY.
- While ready=0:
  - rd_data forced to 0 and rd_busy to 0.
  - wr_en and issue_en ignored; no state change besides the sweep.
- Reads are combinational from the register array:
  - rd_addr == 0 returns 0.
  - Ports are fully independent; any ports may share an address.
- Writes:
  - wr_en=1 and wr_addr != 0 updates register[wr_addr] at the rising edge.
  - Visible on reads from the following cycle.
  - Writes to address 0 are dropped.
- Bypass (BYPASS=1): if wr_en=1, wr_addr != 0 and rd_addr[p] == wr_addr, then rd_data[p] = wr_data in the same cycle. BYPASS=0: old value until the next cycle.
- Scoreboard:
  - issue_en=1 and issue_rd != 0 sets busy[issue_rd] at the edge.
  - wr_en=1 and wr_addr != 0 clears busy[wr_addr].
  - Same cycle, same address: set wins (newer producer).
  - busy[0] is always 0.
- rd_busy[p] = busy[rd_addr[p]], masked to 0 when BYPASS=1 and a matching write is present this cycle.
- Widths:
  - No arithmetic on data.
  - Sweep counter is AW+1 bits so that NREGS is reachable without wrap.
  - Addresses are never out of range (NREGS = 2^AW).

Decomposition:
- Shared package regfile_pkg holds:
  - rf_state_t enum {RF_CLEAR, RF_READY}.
  - Constant RF_ZERO_ADDR = 0.
  - Helper function for the address width.
- Natural sub-module: reg_scoreboard, owning the busy-bit vector, set/clear priority and the per-port rd_busy lookup with bypass masking.

Test Plan:
- Reset sweep: reset high 2 cycles, then low, NREGS=32, SWEEP=1 -> ready=0 for exactly 32 cycles, then 1; every register reads 0. Reset reasserted at sweep cycle 10 -> sweep restarts, a full 32 more cycles before ready.
- Write/read: write 0xDEADBEEF to x5, BYPASS=0 -> same-cycle read of x5 returns old 0; next cycle both ports return 0xDEADBEEF.
- Bypass: BYPASS=1, write 0x1234 to x7 while port0=x7 and port1=x7 -> both read 0x1234 in the write cycle. Write to x0 with value 0xFFFF -> x0 reads 0 in that cycle and afterwards.
- Scoreboard: issue x9 -> rd_busy=1 for x9 the next cycle. Write x9 with BYPASS=1 -> rd_busy=0 in the write cycle. Simultaneous issue x9 and write x9 -> busy stays 1.
- Not ready: during sweep, wr_en to x3 with 0xAA and issue_en to x3 -> after ready, x3 reads 0 and is not busy.
- Multi-port: NRD=3, ports at x1, x2 and x1 after writing 11, 22 -> rd_data = 11, 22, 11.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_ZERO_ADDR = 0;

    function automatic int rf_addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per architectural register,
// with per-port lookup masked by a same-cycle write when bypass is enabled.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = rf_addr_width(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ready,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_rd,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             issue_fire;
    logic             wr_fire;

    assign issue_fire = ready && issue_en && (issue_rd != AW'(RF_ZERO_ADDR));
    assign wr_fire    = ready && wr_en && (wr_addr != AW'(RF_ZERO_ADDR));

    // Set is applied after clear so a newly issued producer wins over a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_busy_port
        logic [AW-1:0] addr;
        logic          fwd_hit;
        assign addr        = rd_addr[gi*AW +: AW];
        assign fwd_hit     = (BYPASS != 0) && wr_fire && (addr == wr_addr);
        assign rd_busy[gi] = ready && busy_q[addr] && !fwd_hit;
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with one write port, optional write bypass,
// busy-bit scoreboard and a post-reset clearing sweep gating the ready flag.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int SWEEP  = 1,
    localparam int AW    = rf_addr_width(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    output logic                ready
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NREGS - 1);

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_fire;

    assign ready   = (state_q == RF_READY);
    assign wr_fire = ready && wr_en && (wr_addr != AW'(RF_ZERO_ADDR));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                if (SWEEP != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = RF_READY;
                    end
                end else begin
                    state_d = RF_READY;
                end
            end
            RF_READY: state_d = RF_READY;
            default:  state_d = RF_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep clears one entry per cycle; the non-sweep build clears everything under reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (SWEEP == 0) begin
                for (int i = 0; i < NREGS; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else if (!ready) begin
            if (SWEEP != 0) begin
                mem_q[cnt_q[AW-1:0]] <= '0;
            end
        end else if (wr_fire) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_port
        logic [AW-1:0] addr;
        assign addr = rd_addr[gi*AW +: AW];
        always_comb begin
            rd_data[gi*XLEN +: XLEN] = '0;
            if (ready && (addr != AW'(RF_ZERO_ADDR))) begin
                if ((BYPASS != 0) && wr_fire && (addr == wr_addr)) begin
                    rd_data[gi*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[gi*XLEN +: XLEN] = mem_q[addr];
                end
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .ready    (ready),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: instance A (3 ports, bypass, sweep) and instance B (2 ports, no bypass, no sweep).
module tb_register_file_mp;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] rd_addr_a;
    logic [95:0] rd_data_a;
    logic [2:0]  rd_busy_a;
    logic        ready_a;
    logic [9:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic [1:0]  rd_busy_b;
    logic        ready_b;
    logic        wr_en, wr_en_b;
    logic        issue_en, issue_en_b;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  issue_rd;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          n;

    always #5 clock = ~clock;

    register_file_mp #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(1), .SWEEP(1)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .ready    (ready_a)
    );

    register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .SWEEP(0)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .wr_en    (wr_en_b),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en_b),
        .issue_rd (issue_rd),
        .ready    (ready_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_en_b = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_en_b    = 1'b0;
        issue_en   = 1'b0;
        issue_en_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        wr_addr   = '0;
        wr_data   = '0;
        issue_rd  = '0;
        rd_addr_a = {5'd3, 5'd2, 5'd1};
        rd_addr_b = {5'd2, 5'd1};
        @(negedge clock);
        tick();
        check_eq("reset_ready_a", ready_a, 0);
        check_eq("reset_ready_b", ready_b, 0);
        check_eq("reset_rd_data_a", rd_data_a, 0);
        check_eq("reset_rd_busy_a", rd_busy_a, 0);
        tick();

        // Initial sweep: A needs 32 cycles, B one cycle.
        reset = 1'b0;
        #1;
        check_eq("b_ready_pre", ready_b, 0);
        n = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
            if (n == 1) check_eq("b_ready_after_1", ready_b, 1);
        end
        check_eq("sweep_len", n, 32);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = {3{i[4:0]}};
            tick();
            check_eq($sformatf("zero_x%0d", i), rd_data_a[31:0], 0);
        end

        // Restarted sweep with writes and issues attempted while not ready.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'hAA;
        issue_en  = 1'b1;
        issue_rd  = 5'd3;
        rd_addr_a = {5'd3, 5'd3, 5'd3};
        for (int i = 0; i < 10; i++) tick();
        check_eq("sweep_mid_ready", ready_a, 0);
        check_eq("sweep_mid_rd_data", rd_data_a, 0);
        check_eq("sweep_mid_rd_busy", rd_busy_a, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
        end
        idle();
        #1;
        check_eq("restart_len", n, 32);
        check_eq("x3_not_written", rd_data_a[31:0], 0);
        check_eq("x3_not_busy", rd_busy_a[0], 0);

        // Write/read: B shows old value in write cycle, A forwards.
        rd_addr_a = {5'd0, 5'd0, 5'd5};
        rd_addr_b = {5'd5, 5'd5};
        drive_write(5'd5, 32'hDEADBEEF);
        #1;
        check_eq("nobyp_same_cycle", rd_data_b[31:0], 0);
        check_eq("byp_same_cycle_x5", rd_data_a[31:0], 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check_eq("nobyp_next_p0", rd_data_b[31:0], 32'hDEADBEEF);
        check_eq("nobyp_next_p1", rd_data_b[63:32], 32'hDEADBEEF);

        rd_addr_a = {5'd0, 5'd7, 5'd7};
        drive_write(5'd7, 32'h1234);
        #1;
        check_eq("byp_x7_p0", rd_data_a[31:0], 32'h1234);
        check_eq("byp_x7_p1", rd_data_a[63:32], 32'h1234);
        tick();
        rd_addr_a = {5'd0, 5'd0, 5'd0};
        rd_addr_b = {5'd0, 5'd0};
        drive_write(5'd0, 32'hFFFF);
        #1;
        check_eq("x0_write_cycle", rd_data_a[31:0], 0);
        tick();
        idle();
        #1;
        check_eq("x0_after_a", rd_data_a[31:0], 0);
        check_eq("x0_after_b", rd_data_b[31:0], 0);

        // Scoreboard set, bypass-masked clear, set-wins priority.
        rd_addr_a  = {5'd0, 5'd0, 5'd9};
        rd_addr_b  = {5'd0, 5'd9};
        issue_en   = 1'b1;
        issue_en_b = 1'b1;
        issue_rd   = 5'd9;
        #1;
        check_eq("busy_before_edge", rd_busy_a[0], 0);
        tick();
        idle();
        #1;
        check_eq("busy_x9_a", rd_busy_a[0], 1);
        check_eq("busy_x9_b", rd_busy_b[0], 1);
        drive_write(5'd9, 32'h99);
        #1;
        check_eq("busy_masked_a", rd_busy_a[0], 0);
        check_eq("busy_unmasked_b", rd_busy_b[0], 1);
        tick();
        idle();
        #1;
        check_eq("busy_cleared_a", rd_busy_a[0], 0);
        check_eq("busy_cleared_b", rd_busy_b[0], 0);
        issue_en   = 1'b1;
        issue_en_b = 1'b1;
        tick();
        drive_write(5'd9, 32'h98);
        tick();
        idle();
        #1;
        check_eq("set_wins_a", rd_busy_a[0], 1);
        check_eq("set_wins_b", rd_busy_b[0], 1);
        check_eq("x9_data_b", rd_data_b[31:0], 32'h98);

        // Multi-port read with shared addresses.
        drive_write(5'd1, 32'd11);
        tick();
        drive_write(5'd2, 32'd22);
        tick();
        idle();
        rd_addr_a = {5'd1, 5'd2, 5'd1};
        rd_addr_b = {5'd2, 5'd1};
        #1;
        check_eq("mp_p0", rd_data_a[31:0], 32'd11);
        check_eq("mp_p1", rd_data_a[63:32], 32'd22);
        check_eq("mp_p2", rd_data_a[95:64], 32'd11);
        check_eq("mp_b_p0", rd_data_b[31:0], 32'd11);
        check_eq("mp_b_p1", rd_data_b[63:32], 32'd22);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
